// File: rtl/lfsr_stream_checker.sv
// Self-synchronising checker for an x^8+x^6+x^5+x^4+1 PRBS stream.
// Fills a local LFSR copy from the line, qualifies it, then flywheels and counts bit errors.
module lfsr_stream_checker (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  typedef enum logic [1:0] {StFill, StSync, StLocked} state_e;

  logic       clk, rst_n, din, din_valid, clr, inv;
  logic [1:0] thresh_sel;

  assign clk        = io_in[0];
  assign rst_n      = io_in[1];
  assign din        = io_in[2];
  assign din_valid  = io_in[3];
  assign clr        = io_in[4];
  assign inv        = io_in[5];
  assign thresh_sel = io_in[7:6];

  state_e     state_q, state_d;
  logic [7:0] hist_q, hist_d;
  logic [2:0] fill_cnt_q, fill_cnt_d;
  logic [6:0] match_cnt_q, match_cnt_d;
  logic [1:0] miss_run_q, miss_run_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic       lost_q, lost_d;
  logic       err_pulse_q, err_pulse_d;

  logic       pred, exp_bit, match;
  logic [6:0] thresh, match_inc;
  logic [1:0] miss_inc;

  assign pred      = hist_q[7] ^ hist_q[5] ^ hist_q[4] ^ hist_q[3];
  assign exp_bit   = pred ^ inv;
  assign match     = (din == exp_bit);
  assign thresh    = 7'd8 << thresh_sel;
  assign match_inc = match_cnt_q + 7'd1;
  assign miss_inc  = miss_run_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    fill_cnt_d  = fill_cnt_q;
    match_cnt_d = match_cnt_q;
    miss_run_d  = miss_run_q;
    err_cnt_d   = err_cnt_q;
    lost_d      = lost_q;
    err_pulse_d = 1'b0;

    if (din_valid) begin
      unique case (state_q)
        StFill: begin
          hist_d = {hist_q[6:0], din};
          if (fill_cnt_q == 3'd7) begin
            fill_cnt_d  = 3'd0;
            match_cnt_d = 7'd0;
            state_d     = StSync;
          end else begin
            fill_cnt_d = fill_cnt_q + 3'd1;
          end
        end
        StSync: begin
          hist_d = {hist_q[6:0], din};
          if (match) begin
            match_cnt_d = match_inc;
            if (match_inc >= thresh) state_d = StLocked;
          end else begin
            match_cnt_d = 7'd0;
          end
        end
        StLocked: begin
          // Flywheel on the expected line bit so hist stays in the received polarity.
          hist_d = {hist_q[6:0], exp_bit};
          if (!match) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != 5'd31) err_cnt_d = err_cnt_q + 5'd1;
            miss_run_d = miss_inc;
            if (miss_inc == 2'd2) begin
              lost_d      = 1'b1;
              hist_d      = 8'h00;
              fill_cnt_d  = 3'd0;
              match_cnt_d = 7'd0;
              miss_run_d  = 2'd0;
              state_d     = StFill;
            end
          end else begin
            miss_run_d = 2'd0;
          end
        end
        default: state_d = StFill;
      endcase
    end

    // Clear overrides any same-edge increment or lock-loss flag.
    if (clr) begin
      err_cnt_d = 5'd0;
      lost_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      hist_q      <= 8'h00;
      fill_cnt_q  <= 3'd0;
      match_cnt_q <= 7'd0;
      miss_run_q  <= 2'd0;
      err_cnt_q   <= 5'd0;
      lost_q      <= 1'b0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      fill_cnt_q  <= fill_cnt_d;
      match_cnt_q <= match_cnt_d;
      miss_run_q  <= miss_run_d;
      err_cnt_q   <= err_cnt_d;
      lost_q      <= lost_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign io_out = {err_cnt_q, lost_q, err_pulse_q, (state_q == StLocked)};

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: fill/lock, errors, loss, saturation, gaps, reset.
module tb_lfsr_stream_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       clr = 1'b0;
  logic       inv = 1'b0;
  logic [1:0] thresh_sel = 2'b00;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [7:0] g;
  int         n_cmp = 0;
  int         n_fail = 0;

  assign io_in = {thresh_sel, inv, clr, din_valid, din, rst_n, clk};

  lfsr_stream_checker dut (
    .io_in (io_in),
    .io_out(io_out)
  );

  always #5 clk = ~clk;

  // Reference generator: same recurrence, output bit is the newly formed bit.
  task automatic gen_bit(output logic b);
    b = g[7] ^ g[5] ^ g[4] ^ g[3];
    g = {g[6:0], b};
  endtask

  task automatic beat(input logic d, input logic v);
    din       = d;
    din_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      $display("FAIL reset_state: got %h want %h", io_out, 8'h00);
      n_fail++;
    end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_fill_lock();
    logic b;
    logic want;
    g = 8'h01;
    for (int k = 1; k <= 16; k++) begin
      gen_bit(b);
      beat(b, 1'b1);
      want = (k == 16);
      n_cmp++;
      if (io_out[0] !== want) begin
        $display("FAIL fill_lock beat %0d: locked got %b want %b", k, io_out[0], want);
        n_fail++;
      end
    end
    for (int k = 0; k < 200; k++) begin
      gen_bit(b);
      beat(b, 1'b1);
      n_cmp++;
      if (io_out !== 8'h01) begin
        $display("FAIL clean_run beat %0d: io_out got %h want %h", k, io_out, 8'h01);
        n_fail++;
      end
    end
  endtask

  task automatic test_single_error();
    logic b;
    gen_bit(b);
    beat(~b, 1'b1);
    n_cmp++;
    if (io_out !== 8'h0B) begin
      $display("FAIL single_err: io_out got %h want %h", io_out, 8'h0B);
      n_fail++;
    end
    for (int k = 0; k < 10; k++) begin
      gen_bit(b);
      beat(b, 1'b1);
      n_cmp++;
      if (io_out !== 8'h09) begin
        $display("FAIL single_err_after %0d: io_out got %h want %h", k, io_out, 8'h09);
        n_fail++;
      end
    end
  endtask

  task automatic test_loss();
    logic       b;
    logic [7:0] want;
    clr = 1'b1;
    gen_bit(b);
    beat(b, 1'b1);
    clr = 1'b0;
    n_cmp++;
    if (io_out !== 8'h01) begin
      $display("FAIL loss_preclear: io_out got %h want %h", io_out, 8'h01);
      n_fail++;
    end
    gen_bit(b);
    beat(~b, 1'b1);
    n_cmp++;
    if (io_out !== 8'h0B) begin
      $display("FAIL loss_first_err: io_out got %h want %h", io_out, 8'h0B);
      n_fail++;
    end
    gen_bit(b);
    beat(~b, 1'b1);
    n_cmp++;
    if (io_out !== 8'h16) begin
      $display("FAIL loss_second_err: io_out got %h want %h", io_out, 8'h16);
      n_fail++;
    end
    for (int k = 1; k <= 16; k++) begin
      gen_bit(b);
      beat(b, 1'b1);
      want = (k == 16) ? 8'h15 : 8'h14;
      n_cmp++;
      if (io_out !== want) begin
        $display("FAIL relock beat %0d: io_out got %h want %h", k, io_out, want);
        n_fail++;
      end
    end
  endtask

  task automatic test_saturation_clear();
    logic       b;
    logic [4:0] exp_cnt;
    logic [7:0] want;
    exp_cnt = 5'd2;
    for (int i = 0; i < 40; i++) begin
      gen_bit(b);
      beat(~b, 1'b1);
      if (exp_cnt != 5'd31) exp_cnt = exp_cnt + 5'd1;
      want = {exp_cnt, 3'b111};
      n_cmp++;
      if (io_out !== want) begin
        $display("FAIL sat_err %0d: io_out got %h want %h", i, io_out, want);
        n_fail++;
      end
      gen_bit(b);
      beat(b, 1'b1);
    end
    n_cmp++;
    if (io_out !== 8'hFD) begin
      $display("FAIL sat_final: io_out got %h want %h", io_out, 8'hFD);
      n_fail++;
    end
    clr = 1'b1;
    gen_bit(b);
    beat(~b, 1'b1);
    clr = 1'b0;
    n_cmp++;
    if (io_out !== 8'h03) begin
      $display("FAIL clr_with_err: io_out got %h want %h", io_out, 8'h03);
      n_fail++;
    end
    gen_bit(b);
    beat(b, 1'b1);
    n_cmp++;
    if (io_out !== 8'h01) begin
      $display("FAIL clr_after: io_out got %h want %h", io_out, 8'h01);
      n_fail++;
    end
  endtask

  task automatic test_clr_on_loss();
    logic b;
    gen_bit(b);
    beat(~b, 1'b1);
    n_cmp++;
    if (io_out !== 8'h0B) begin
      $display("FAIL clrloss_first: io_out got %h want %h", io_out, 8'h0B);
      n_fail++;
    end
    clr = 1'b1;
    gen_bit(b);
    beat(~b, 1'b1);
    clr = 1'b0;
    n_cmp++;
    if (io_out !== 8'h02) begin
      $display("FAIL clrloss_second: io_out got %h want %h", io_out, 8'h02);
      n_fail++;
    end
  endtask

  task automatic test_threshold_gaps();
    logic       b;
    logic       junk;
    logic [7:0] want;
    thresh_sel = 2'b11;
    for (int vb = 1; vb <= 72; vb++) begin
      gen_bit(b);
      beat(b, 1'b1);
      want = (vb == 72) ? 8'h01 : 8'h00;
      n_cmp++;
      if (io_out !== want) begin
        $display("FAIL thresh64 beat %0d: io_out got %h want %h", vb, io_out, want);
        n_fail++;
      end
      for (int j = 0; j < 2; j++) begin
        junk = 1'($urandom_range(1, 0));
        beat(junk, 1'b0);
        n_cmp++;
        if (io_out !== want) begin
          $display("FAIL gap beat %0d.%0d: io_out got %h want %h", vb, j, io_out, want);
          n_fail++;
        end
      end
    end
    thresh_sel = 2'b00;
  endtask

  task automatic test_async_reset_inv();
    logic       b;
    logic [7:0] want;
    gen_bit(b);
    beat(~b, 1'b1);
    n_cmp++;
    if (io_out !== 8'h0B) begin
      $display("FAIL prereset_err: io_out got %h want %h", io_out, 8'h0B);
      n_fail++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      $display("FAIL async_reset: io_out got %h want %h", io_out, 8'h00);
      n_fail++;
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (io_out !== 8'h00) begin
      $display("FAIL reset_hold: io_out got %h want %h", io_out, 8'h00);
      n_fail++;
    end
    #3 rst_n = 1'b1;
    inv = 1'b1;
    g   = 8'h01;
    for (int k = 1; k <= 16; k++) begin
      gen_bit(b);
      beat(~b, 1'b1);
      want = (k == 16) ? 8'h01 : 8'h00;
      n_cmp++;
      if (io_out !== want) begin
        $display("FAIL inv_lock beat %0d: io_out got %h want %h", k, io_out, want);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_lock();
    test_single_error();
    test_loss();
    test_saturation_clear();
    test_clr_on_loss();
    test_threshold_gaps();
    test_async_reset_inv();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
